// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: AW, W, B, AR and R channels.
// The slave modport drives the ready/response side; the master drives the rest.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        input  ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP,
        output ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        output ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP,
        input  ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file with independent write and read FSMs.
// Define AXIL_SLV_DECERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi_lite_if.slave                      S_AXI_LITE,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int LP_STRB = DATA_WIDTH / 8;
    localparam int LP_B    = $clog2(LP_STRB);
    localparam int LP_IW   = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LP_SPAN =
        (ADDR_WIDTH+1)'(NUM_REGS * LP_STRB);
    localparam logic [1:0] LP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_RESP_EN
    localparam logic [1:0] LP_ERR  = 2'b10;
`else
    localparam logic [1:0] LP_ERR  = 2'b00;
`endif

    typedef enum logic [1:0] {
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP
    } wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate, w_wnext;
    rstate_t r_rstate, w_rnext;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LP_STRB-1:0]    r_wstrb;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_awready, w_wready, w_arready;
    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [LP_STRB-1:0]    w_wr_strb;
    logic                  w_wr_inrange, w_rd_inrange;
    logic [LP_IW-1:0]      w_wr_idx, w_rd_idx;

    assign w_awready = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_DATA);
    assign w_wready  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_ADDR);
    assign w_arready = (r_rstate == R_IDLE);
    assign w_aw_hs   = S_AXI_LITE.AWVALID & w_awready;
    assign w_w_hs    = S_AXI_LITE.WVALID & w_wready;
    assign w_ar_hs   = S_AXI_LITE.ARVALID & w_arready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wnext = W_RESP;
                else if (w_aw_hs)      w_wnext = W_HAVE_ADDR;
                else if (w_w_hs)       w_wnext = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_w_hs)  w_wnext = W_RESP;
            W_HAVE_DATA: if (w_aw_hs) w_wnext = W_RESP;
            W_RESP: if (S_AXI_LITE.BREADY) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rnext = R_DATA;
            R_DATA: if (S_AXI_LITE.RREADY) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // The beat arriving on the committing edge bypasses its capture register.
    assign w_commit  = (r_wstate != W_RESP) && (w_wnext == W_RESP);
    assign w_wr_addr = w_aw_hs ? S_AXI_LITE.AWADDR : r_awaddr;
    assign w_wr_data = w_w_hs ? S_AXI_LITE.WDATA : r_wdata;
    assign w_wr_strb = w_w_hs ? S_AXI_LITE.WSTRB : r_wstrb;
    assign w_wr_inrange = {1'b0, w_wr_addr} < LP_SPAN;
    assign w_wr_idx  = w_wr_addr[LP_IW+LP_B-1:LP_B];
    assign w_rd_inrange = {1'b0, S_AXI_LITE.ARADDR} < LP_SPAN;
    assign w_rd_idx  = S_AXI_LITE.ARADDR[LP_IW+LP_B-1:LP_B];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= LP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= S_AXI_LITE.AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_LITE.WDATA;
                r_wstrb <= S_AXI_LITE.WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_inrange ? LP_OKAY : LP_ERR;
                if (w_wr_inrange) begin
                    for (int k = 0; k < LP_STRB; k++) begin
                        if (w_wr_strb[k])
                            r_regs[w_wr_idx][k*8 +: 8] <= w_wr_data[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data samples the register array before any same-edge write lands.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdata <= '0;
            r_rresp <= LP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_inrange ? r_regs[w_rd_idx] : '0;
            r_rresp <= w_rd_inrange ? LP_OKAY : LP_ERR;
        end
    end

    assign S_AXI_LITE.AWREADY = w_awready;
    assign S_AXI_LITE.WREADY  = w_wready;
    assign S_AXI_LITE.BVALID  = (r_wstate == W_RESP);
    assign S_AXI_LITE.BRESP   = r_bresp;
    assign S_AXI_LITE.ARREADY = w_arready;
    assign S_AXI_LITE.RVALID  = (r_rstate == R_DATA);
    assign S_AXI_LITE.RDATA   = r_rdata;
    assign S_AXI_LITE.RRESP   = r_rresp;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: random AXI-Lite traffic
// against an array model; a monitor checks every B and R beat.
module tb_axi_lite_slave_regs;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
`ifdef AXIL_SLV_DECERR_RESP_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESETn;
    logic [NR*DW-1:0] reg_out;

    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_slave_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .S_AXI_LITE(bus.slave),
        .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NR];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < NR * DW / 8;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return in_range(a) ? model[a / 4] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_range(a) ? 2'b00 : ERR;
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        if (in_range(a))
            for (int k = 0; k < 4; k++)
                if (s[k]) model[a / 4][k*8 +: 8] = d[k*8 +: 8];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk(tag, 64'(reg_out[i*DW +: DW]), 64'(model[i]));
    endtask

    // Monitor: pops expected responses on each B/R handshake.
    bit bpend, rpend;
    logic [1:0]  bprev;
    logic [33:0] rprev;
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            bpend = 0;
            rpend = 0;
        end else begin
            if (bpend)
                chk("b_held", 64'({bus.BVALID, bus.BRESP}), 64'({1'b1, bprev}));
            if (rpend)
                chk("r_held", 64'({bus.RVALID, bus.RRESP, bus.RDATA}),
                    64'({1'b1, rprev}));
            if (bus.BVALID)
                chk("aw_w_ready_in_resp", 64'({bus.AWREADY, bus.WREADY}), 64'(0));
            if (bus.RVALID)
                chk("arready_in_rdata", 64'(bus.ARREADY), 64'(0));
            if (bus.BVALID && bus.BREADY) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
                else chk("bresp", 64'(bus.BRESP), 64'(bq.pop_front()));
            end
            if (bus.RVALID && bus.RREADY) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(1), 64'(0));
                else chk("rdata_rresp", 64'({bus.RRESP, bus.RDATA}),
                         64'(rq.pop_front()));
            end
            bpend = bus.BVALID && !bus.BREADY;
            bprev = bus.BRESP;
            rpend = bus.RVALID && !bus.RREADY;
            rprev = {bus.RRESP, bus.RDATA};
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aws, input int ws,
                            input int bdel);
        int  c = 0;
        bit  awd = 0, wd = 0, awn, wn, done;
        model_write(a, d, s);
        bq.push_back(exp_resp(a));
        bus.AWADDR = a;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        while (!(awd && wd) && c < 50) begin
            bus.AWVALID = !awd && c >= aws;
            bus.WVALID  = !wd && c >= ws;
            @(negedge ACLK);
            awn = bus.AWVALID && bus.AWREADY;
            wn  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            awd |= awn;
            wd  |= wn;
            c++;
        end
        bus.AWVALID = 0;
        bus.WVALID  = 0;
        if (!(awd && wd)) chk("aw_w_timeout", 64'(0), 64'(1));
        bus.BREADY = (bdel == 0);
        @(negedge ACLK);
        chk("bvalid_latency", 64'(bus.BVALID), 64'(1));
        @(posedge ACLK); #1;
        if (bdel > 0) begin
            repeat (bdel - 1) begin @(posedge ACLK); #1; end
            bus.BREADY = 1;
            c = 0;
            done = 0;
            while (!done && c < 50) begin
                @(negedge ACLK);
                done = bus.BVALID;
                @(posedge ACLK); #1;
                c++;
            end
            if (!done) chk("b_timeout", 64'(0), 64'(1));
        end
        bus.BREADY = 0;
        check_regs("reg_out");
    endtask

    task automatic do_read(input logic [31:0] a, input int rdel,
                           input logic [31:0] ed, input logic [1:0] er);
        int c = 0;
        bit done = 0;
        rq.push_back({er, ed});
        bus.ARADDR  = a;
        bus.ARVALID = 1;
        while (!done && c < 50) begin
            @(negedge ACLK);
            done = bus.ARREADY;
            @(posedge ACLK); #1;
            c++;
        end
        bus.ARVALID = 0;
        if (!done) chk("ar_timeout", 64'(0), 64'(1));
        bus.RREADY = (rdel == 0);
        @(negedge ACLK);
        chk("rvalid_latency", 64'(bus.RVALID), 64'(1));
        @(posedge ACLK); #1;
        if (rdel > 0) begin
            repeat (rdel - 1) begin @(posedge ACLK); #1; end
            bus.RREADY = 1;
            c = 0;
            done = 0;
            while (!done && c < 50) begin
                @(negedge ACLK);
                done = bus.RVALID;
                @(posedge ACLK); #1;
                c++;
            end
            if (!done) chk("r_timeout", 64'(0), 64'(1));
        end
        bus.RREADY = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valids"}, 64'({bus.BVALID, bus.RVALID}), 64'(0));
        chk({tag, "_resps"}, 64'({bus.BRESP, bus.RRESP}), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.RDATA), 64'(0));
        chk({tag, "_readies"},
            64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(3'b111));
        chk({tag, "_reg_out"}, 64'(|reg_out), 64'(0));
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return $urandom_range(32, 300);
        return $urandom_range(0, NR - 1) * 4 + $urandom_range(0, 3);
    endfunction

    initial begin
        logic [31:0] a, old;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0;
        bus.WDATA = 0; bus.WSTRB = 0; bus.BREADY = 0;
        bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 0;
        for (int i = 0; i < NR; i++) model[i] = 0;
        ARESETn = 1;
        #1 ARESETn = 0;
        #2 check_idle("in_reset");
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1;
        #2 check_idle("post_reset");
        @(posedge ACLK); #1;

        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 2, 0);
        chk("reg1_deadbeef", 64'(reg_out[63:32]), 64'(32'hDEADBEEF));
        do_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(32'h8, 32'h11223344, 4'h3, 2, 0, 1);
        chk("reg2_merge", 64'(reg_out[95:64]), 64'(32'hAABB3344));
        do_write(32'h0, 32'h0BADF00D, 4'hF, 0, 0, 5);
        do_write(32'hC, 32'h12345678, 4'h0, 1, 0, 2);
        do_read(32'h4, 3, 32'hDEADBEEF, 2'b00);
        do_write(32'h20, 32'h1, 4'hF, 0, 0, 0);
        do_read(32'h20, 1, 32'h0, ERR);

        // AR lands on the same edge as a write to the same register.
        a = 32'h4;
        old = exp_rdata(a);
        fork
            do_write(a, 32'hCAFEF00D, 4'hF, 0, 0, 0);
            do_read(a, 0, old, 2'b00);
        join
        do_read(a, 0, 32'hCAFEF00D, 2'b00);

        // Reset while in W_HAVE_ADDR and R_DATA.
        bus.AWADDR = 32'h10; bus.AWVALID = 1;
        @(posedge ACLK); #1;
        bus.AWVALID = 0;
        bus.ARADDR = 32'h4; bus.ARVALID = 1;
        @(posedge ACLK); #1;
        bus.ARVALID = 0;
        @(posedge ACLK); #1;
        ARESETn = 0;
        for (int i = 0; i < NR; i++) model[i] = 0;
        #2 check_idle("mid_reset");
        @(posedge ACLK); #1;
        ARESETn = 1;
        @(posedge ACLK); #1;
        do_write(32'h10, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        do_read(32'h10, 0, 32'h5A5A5A5A, 2'b00);
        do_read(32'h4, 0, 32'h0, 2'b00);

        for (int n = 0; n < 200; n++) begin
            a = rand_addr();
            if ($urandom_range(0, 2) != 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3), exp_rdata(a), exp_resp(a));
        end

        repeat (3) @(posedge ACLK);
        chk("bq_drained", 64'(bq.size()), 64'(0));
        chk("rq_drained", 64'(rq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of AW/AR channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width; SHALL be 32 or 64.
REQ-003 Parameter NUM_REGS, default 8, register count; power of two, >=2.
REQ-004 Port ACLK  input  1  single clock; all state changes on posedge.
REQ-005 Port ARESETn  input  1  asynchronous, active-low reset.
REQ-006 Port S_AXI_LITE  interface (axi_lite_if.slave)  ADDR_WIDTH/DATA_WIDTH  AW, W, B, AR, R channels; drives AWREADY, WREADY, BVALID, BRESP[1:0], ARREADY, RVALID, RDATA, RRESP[1:0].
REQ-007 Port reg_out  output  NUM_REGS*DATA_WIDTH  flattened register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-008 Register index = addr[$clog2(NUM_REGS)+B-1 : B], B = $clog2(DATA_WIDTH/8); addr[B-1:0] ignored.
REQ-009 Address in range when addr < NUM_REGS*DATA_WIDTH/8; otherwise out of range.
REQ-010 Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-011 AWREADY = 1 in W_IDLE and W_HAVE_DATA; WREADY = 1 in W_IDLE and W_HAVE_ADDR; both 0 otherwise.
REQ-012 AW handshake captures AWADDR; W handshake captures WDATA and WSTRB; order of AW and W SHALL NOT matter.
REQ-013 W_IDLE: AW only -> W_HAVE_ADDR; W only -> W_HAVE_DATA; AW and W same cycle -> W_RESP.
REQ-014 W_HAVE_ADDR on W handshake, or W_HAVE_DATA on AW handshake -> W_RESP.
REQ-015 Register update occurs on the clock edge entering W_RESP; byte lane k written only when WSTRB[k]=1; WSTRB=0 leaves register unchanged yet still completes with response.
REQ-016 Out-of-range write SHALL modify no register.
REQ-017 W_RESP: BVALID=1, BRESP held stable; BVALID & BREADY -> W_IDLE; BVALID stays high indefinitely while BREADY=0.
REQ-018 Minimum write latency: BVALID asserted the cycle after the last of AW/W handshakes.
REQ-019 Read FSM states: R_IDLE, R_DATA; ARREADY = 1 only in R_IDLE.
REQ-020 AR handshake in R_IDLE registers RDATA (register value at that edge) and RRESP, -> R_DATA; RVALID=1 next cycle.
REQ-021 R_DATA: RDATA/RRESP held stable; RVALID & RREADY -> R_IDLE.
REQ-022 Out-of-range read returns RDATA = 0.
REQ-023 Read and write FSMs independent; AR handshake on the same edge as a write update to the same register returns the pre-write value.
REQ-024 RESP encoding: OKAY = 2'b00, SLVERR = 2'b10.

Reset
REQ-025 ARESETn low, asynchronously: write FSM -> W_IDLE, read FSM -> R_IDLE, all registers and reg_out = 0.
REQ-026 During and after reset: BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0; AWREADY=WREADY=ARREADY=1 (W_IDLE/R_IDLE decode).
REQ-027 Reset mid-transaction abandons it: no pending response, captured address/data discarded, no register write.

Configuration
REQ-028 Macro AXIL_SLV_DECERR_RESP_EN: when defined, out-of-range writes return BRESP=SLVERR and out-of-range reads return RRESP=SLVERR with RDATA=0.
REQ-029 Without AXIL_SLV_DECERR_RESP_EN, out-of-range accesses return OKAY; no-write and RDATA=0 behaviour unchanged.

Verification
REQ-030 Reset, AW(0x4) then W(0xDEADBEEF, WSTRB=0xF) on later cycle, BREADY=1 -> BVALID next cycle after W, BRESP=OKAY, reg_out reg1=0xDEADBEEF.
REQ-031 W(0x11223344, WSTRB=0x3) before AW(0x8), reg2 preloaded 0xAABBCCDD -> reg2=0xAABB3344, one BVALID pulse.
REQ-032 AW and W same cycle to 0x0, BREADY=0 for 5 cycles -> BVALID held 5 cycles, AWREADY=WREADY=0 throughout; B handshake then returns to W_IDLE.
REQ-033 AR(0x4) with RREADY low 3 cycles -> RVALID and RDATA=reg1 stable 3 cycles, ARREADY=0 until R handshake.
REQ-034 Write 0x1 and read 0x20 (NUM_REGS=8, DATA_WIDTH=32) -> no register change; with macro BRESP=RRESP=2'b10, without 2'b00; RDATA=0 both.
REQ-035 ARESETn low while in W_HAVE_ADDR and R_DATA -> BVALID=RVALID=0, all reg_out=0, next AW+W completes normally.
